// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the CPU-side request/response signals (fetch port "i_", data port
// "d_"), the memory-side strobes and the busy flag shared by the arbiter and
// its neighbours.
//   slave  : the arbiter's view (takes requests, drives memory and responses)
//   master : the CPU/memory side's view (drives requests and mem_rdata)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    // fetch port (read only)
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_ready;
    // data port (read/write)
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_ready;
    // memory side
    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    // stall indication for the hazard logic
    logic                 busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ready, d_rdata, d_ready,
               mem_read, mem_write, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready,
               mem_read, mem_write, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between the CPU's fetch port
// (read only) and its data port (read/write). Each access holds the memory
// strobes and address for MEM_LATENCY cycles, then pulses the requester's
// ready for one cycle. The data port has priority, except that fetch wins once
// it has watched STARVE_LIMIT consecutive data grants go by.
// Ports:
//   Clk      : clock, all state updates on the rising edge
//   Reset_N  : synchronous, active-low reset
//   bus      : mem_port_arbiter_if.slave (fetch port, data port, memory
//              strobes/address/data, busy)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 2
) (
    input logic                  Clk,
    input logic                  Reset_N,
    mem_port_arbiter_if.slave    bus
);
    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE_I,
        DONE_D
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [STARVE_W-1:0]   r_starve_cnt;
    logic [WORD_SIZE-1:0]  r_i_rdata;
    logic [WORD_SIZE-1:0]  r_d_rdata;
    logic                  r_i_ready;
    logic                  r_d_ready;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [WORD_SIZE-1:0]  r_mem_addr;
    logic [WORD_SIZE-1:0]  r_mem_wdata;
    logic                  r_busy;

    // Fetch wins when the data port is quiet, or when it has been passed over
    // STARVE_LIMIT times in a row.
    logic w_grant_i;
    logic w_grant_d;
    assign w_grant_i = bus.i_req && (!bus.d_req || (r_starve_cnt == STARVE_W'(STARVE_LIMIT)));
    assign w_grant_d = bus.d_req && !w_grant_i;

    // The memory strobe/address registers double as the latched request: they
    // are loaded at grant and never look at the requester again until DONE.
    always_ff @(posedge Clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous); all state is
        // assigned non-blocking so every register sees pre-edge values.
        if (!Reset_N) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_starve_cnt <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_ready    <= 1'b0;
            r_d_ready    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_state      <= BUSY_I;
                        r_cnt        <= CNT_W'(MEM_LATENCY - 1);
                        r_mem_read   <= 1'b1;
                        r_mem_addr   <= bus.i_addr;
                        r_busy       <= 1'b1;
                        r_starve_cnt <= '0;
                    end else if (w_grant_d) begin
                        r_state     <= BUSY_D;
                        r_cnt       <= CNT_W'(MEM_LATENCY - 1);
                        r_mem_read  <= !bus.d_we;
                        r_mem_write <= bus.d_we;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_we ? bus.d_wdata : '0;
                        r_busy      <= 1'b1;
                        // A data grant with fetch waiting is always below the
                        // limit (otherwise fetch would have won), so +1 saturates.
                        r_starve_cnt <= bus.i_req ? r_starve_cnt + 1'b1 : '0;
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (r_cnt == '0) begin
                        if (r_state == BUSY_I) begin
                            r_i_rdata <= bus.mem_rdata;
                            r_i_ready <= 1'b1;
                            r_state   <= DONE_I;
                        end else begin
                            // writes leave the previous read data in place
                            if (r_mem_read) begin
                                r_d_rdata <= bus.mem_rdata;
                            end
                            r_d_ready <= 1'b1;
                            r_state   <= DONE_D;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE_I, DONE_D: begin
                    // requests are not looked at here, so a stale req held
                    // through the ready pulse cannot re-grant
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i_rdata   = r_i_rdata;
    assign bus.i_ready   = r_i_ready;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_ready   = r_d_ready;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural memory. Expected
// read data is queued per port when a request is issued and compared when
// the matching ready pulse appears; a monitor also checks strobe lengths,
// idle bus values and the order in which the ports complete.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int WS    = 16;
    localparam int ML    = 2;
    localparam int SLIM  = 2;

    logic Clk = 1'b0;
    logic Reset_N;
    int   cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter_if #(.WORD_SIZE(WS)) bus ();

    mem_port_arbiter #(
        .WORD_SIZE    (WS),
        .MEM_LATENCY  (ML),
        .STARVE_LIMIT (SLIM)
    ) dut (
        .Clk     (Clk),
        .Reset_N (Reset_N),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // behavioural single-ported memory
    logic [WS-1:0] mem [0:65535];
    initial begin
        for (int k = 0; k < 65536; k++) mem[k] = '0;
        mem[16'h0010] = 16'hA5A5;
        mem[16'h0020] = 16'hBEEF;
        forever begin
            @(posedge Clk);
            if (bus.mem_write) mem[bus.mem_addr] = bus.mem_wdata;
        end
    end
    always_comb bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr] : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: expected read data per port, and completion order (1 = data)
    logic [WS-1:0] exp_i[$];
    logic [WS-1:0] exp_d[$];
    bit            order[$];
    bit            mon_en = 1'b0;
    int            run = 0;
    bit            run_reset = 1'b0;

    always @(negedge Clk) begin
        if (mon_en) begin
            if (bus.i_ready) begin
                order.push_back(1'b0);
                if (exp_i.size() == 0) check("spurious i_ready", 1, 0);
                else                   check("i_rdata", bus.i_rdata, exp_i.pop_front());
            end
            if (bus.d_ready) begin
                order.push_back(1'b1);
                if (exp_d.size() == 0) check("spurious d_ready", 1, 0);
                else                   check("d_rdata", bus.d_rdata, exp_d.pop_front());
            end
            if (!Reset_N && run != 0) run_reset = 1'b1;
            if (bus.mem_read || bus.mem_write) begin
                run++;
                check("strobes exclusive", bus.mem_read & bus.mem_write, 0);
            end else begin
                check("idle mem_addr", bus.mem_addr, 0);
                check("idle mem_wdata", bus.mem_wdata, 0);
                if (run != 0 && !run_reset) check("strobe length", run, ML);
                run = 0;
                run_reset = 1'b0;
            end
        end
    end

    task automatic wait_for(input bit want_d, input string tag, output int at);
        at = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (want_d ? bus.d_ready : bus.i_ready) begin
                at = cyc;
                return;
            end
        end
        check({tag, " timeout"}, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t_d, t_i, at, seen;
        logic [5:0] pat;

        Reset_N     = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        repeat (3) @(negedge Clk);
        check("reset busy", bus.busy, 0);
        check("reset i_ready", bus.i_ready, 0);
        check("reset d_ready", bus.d_ready, 0);
        check("reset mem_read", bus.mem_read, 0);
        check("reset mem_write", bus.mem_write, 0);
        check("reset i_rdata", bus.i_rdata, 0);
        check("reset d_rdata", bus.d_rdata, 0);
        mon_en  = 1'b1;
        Reset_N = 1'b1;

        // lone fetch
        @(negedge Clk);
        t0 = cyc;
        bus.i_addr = 16'h0010;
        bus.i_req  = 1'b1;
        exp_i.push_back(16'hA5A5);
        @(negedge Clk);
        check("fetch c1 mem_read", bus.mem_read, 1);
        check("fetch c1 mem_write", bus.mem_write, 0);
        check("fetch c1 mem_addr", bus.mem_addr, 16'h0010);
        check("fetch c1 busy", bus.busy, 1);
        @(negedge Clk);
        check("fetch c2 mem_read", bus.mem_read, 1);
        wait_for(1'b0, "fetch i_ready", at);
        bus.i_req = 1'b0;
        check("fetch latency", at - t0, ML + 1);
        check("fetch done mem_read", bus.mem_read, 0);
        check("fetch done busy", bus.busy, 1);
        @(negedge Clk);
        check("fetch idle busy", bus.busy, 0);
        check("fetch ready pulse width", bus.i_ready, 0);

        // data write
        t0 = cyc;
        bus.d_addr  = 16'h0040;
        bus.d_wdata = 16'h1234;
        bus.d_we    = 1'b1;
        bus.d_req   = 1'b1;
        exp_d.push_back(16'h0000);
        @(negedge Clk);
        check("write c1 mem_write", bus.mem_write, 1);
        check("write c1 mem_read", bus.mem_read, 0);
        check("write c1 mem_addr", bus.mem_addr, 16'h0040);
        check("write c1 mem_wdata", bus.mem_wdata, 16'h1234);
        @(negedge Clk);
        check("write c2 mem_write", bus.mem_write, 1);
        wait_for(1'b1, "write d_ready", at);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        check("write latency", at - t0, ML + 1);
        @(negedge Clk);
        check("write idle busy", bus.busy, 0);
        check("write memory contents", mem[16'h0040], 16'h1234);
        check("write d_rdata kept", bus.d_rdata, 16'h0000);

        // simultaneous requests: data first, fetch in the following IDLE
        order.delete();
        t0 = cyc;
        bus.d_addr = 16'h0040;
        bus.d_req  = 1'b1;
        bus.i_addr = 16'h0010;
        bus.i_req  = 1'b1;
        exp_d.push_back(16'h1234);
        exp_i.push_back(16'hA5A5);
        wait_for(1'b1, "both d_ready", t_d);
        bus.d_req = 1'b0;
        wait_for(1'b0, "both i_ready", t_i);
        bus.i_req = 1'b0;
        check("both d latency", t_d - t0, ML + 1);
        check("both i after d", t_i - t_d, ML + 2);
        @(negedge Clk);
        check("both completions", order.size(), 2);
        if (order.size() == 2) check("both data first", order[0], 1);

        // continuous contention: grant order D,D,I,D,D,I
        order.delete();
        for (int k = 0; k < 4; k++) exp_d.push_back(16'h1234);
        for (int k = 0; k < 2; k++) exp_i.push_back(16'hA5A5);
        bus.d_addr = 16'h0040;
        bus.d_req  = 1'b1;
        bus.i_addr = 16'h0010;
        bus.i_req  = 1'b1;
        seen = 0;
        for (int n = 0; n < 60 && seen < 6; n++) begin
            @(negedge Clk);
            if (bus.i_ready || bus.d_ready) seen++;
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        check("starve completions seen", seen, 6);
        repeat (2) @(negedge Clk);
        pat = '0;
        for (int k = 0; k < 6 && k < order.size(); k++) pat[5-k] = order[k];
        check("starve order count", order.size(), 6);
        check("starve order D,D,I,D,D,I", pat, 6'b110110);

        // reset in the first BUSY_D cycle aborts the access
        bus.d_addr = 16'h0040;
        bus.d_req  = 1'b1;
        @(negedge Clk);
        check("abort c1 mem_read", bus.mem_read, 1);
        check("abort c1 busy", bus.busy, 1);
        Reset_N = 1'b0;
        @(negedge Clk);
        check("abort mem_read", bus.mem_read, 0);
        check("abort mem_addr", bus.mem_addr, 0);
        check("abort busy", bus.busy, 0);
        check("abort d_ready", bus.d_ready, 0);
        check("abort d_rdata", bus.d_rdata, 0);
        check("abort i_rdata", bus.i_rdata, 0);
        @(negedge Clk);
        Reset_N   = 1'b1;
        bus.d_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            check("abort stays idle", bus.busy, 0);
        end

        // fetch request dropped mid-access still completes, once
        bus.i_addr = 16'h0020;
        bus.i_req  = 1'b1;
        exp_i.push_back(16'hBEEF);
        @(negedge Clk);
        check("drop c1 mem_addr", bus.mem_addr, 16'h0020);
        bus.i_req  = 1'b0;
        bus.i_addr = 16'h0030;
        @(negedge Clk);
        check("drop c2 mem_read", bus.mem_read, 1);
        check("drop c2 latched addr", bus.mem_addr, 16'h0020);
        wait_for(1'b0, "drop i_ready", at);
        check("drop d_rdata untouched", bus.d_rdata, 0);
        @(negedge Clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            check("drop no second access", bus.busy | bus.mem_read, 0);
        end

        check("fetch queue drained", exp_i.size(), 0);
        check("data queue drained", exp_d.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
